// File: rtl/bridge_pkg.sv
// Shared types for the DRAM bridge arbiter: FSM state encoding and the latched
// request record.
package bridge_pkg;

  localparam int ID_W   = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic              r_wb;
    logic [ID_W-1:0]   addr;
    logic [DATA_W-1:0] data_w;
  } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      grant,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    logic [GW-1:0] cand;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin sharing of the single DRAM bridge request channel between
// NUM_REQ requesters, one outstanding transaction, with a WAIT watchdog.
module bridge_arbiter
  import bridge_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_r_wb,
  input  logic [NUM_REQ*8-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]  req_data_w,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   C_in_valid,
  output logic                   C_r_wb,
  output logic [7:0]             C_addr,
  output logic [31:0]            C_data_w,
  input  logic                   C_out_valid,
  input  logic [31:0]            C_data_r,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    rr_ptr;
  req_t             lat;
  logic [CNT_W-1:0] wd;

  logic [GW-1:0]    arb_grant;
  logic             arb_any;
  logic             wd_limit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign wd_limit = (wd == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      lat         <= '0;
      wd          <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant       <= arb_grant;
            lat.r_wb    <= req_r_wb[arb_grant];
            lat.addr    <= req_addr[arb_grant*ID_W +: ID_W];
            lat.data_w  <= req_data_w[arb_grant*DATA_W +: DATA_W];
            rr_ptr      <= (arb_grant == GW'(NUM_REQ - 1)) ? '0 : arb_grant + 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // A completion arriving on the watchdog limit cycle still counts.
          if (C_out_valid) begin
            resp_data <= C_data_r;
            resp_err  <= 1'b0;
            state     <= RESP;
          end else if (wd_limit) begin
            resp_data   <= '0;
            resp_err    <= 1'b1;
            timeout_err <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel outputs are decoded from registered state and latched fields.
  assign busy       = (state != IDLE);
  assign C_in_valid = (state == ISSUE);
  assign req_ready  = (state == ISSUE) ? (NUM_REQ'(1) << grant) : '0;
  assign resp_valid = (state == RESP)  ? (NUM_REQ'(1) << grant) : '0;
  assign C_r_wb     = (state == ISSUE || state == WAIT) ? lat.r_wb   : 1'b0;
  assign C_addr     = (state == ISSUE || state == WAIT) ? lat.addr   : '0;
  assign C_data_w   = (state == ISSUE || state == WAIT) ? lat.data_w : '0;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed table-driven bench for bridge_arbiter (NUM_REQ=2, TIMEOUT_CYC=8)
// with a bridge model driven from the vector latency field.
module tb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_r_wb;
  logic [15:0] req_addr;
  logic [63:0] req_data_w;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [31:0] C_data_w;
  logic        C_out_valid;
  logic [31:0] C_data_r;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  bit outstanding = 0;

  bridge_arbiter #(
    .NUM_REQ     (2),
    .TIMEOUT_CYC (8),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_r_wb    (req_r_wb),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  rwb;
    logic [15:0] addr;
    logic [63:0] dw;
    int          lat;      // WAIT-relative cycle of C_out_valid; >8 = never
    logic [31:0] rdata;
    int          exp_g;
    logic        exp_err;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // At most one bridge request outstanding between responses.
  always @(posedge clk) begin
    if (!rst_n) outstanding = 0;
    else begin
      if (C_in_valid) begin
        checks++;
        if (outstanding) begin
          failures++;
          $display("FAIL one_outstanding actual=2 required=1");
        end
        outstanding = 1;
      end
      if (resp_valid != 2'b00) outstanding = 0;
    end
  end

  task automatic run_txn(input vec_t v);
    int g;
    int n;
    int exp_n;
    logic [31:0] exp_data;
    g          = v.exp_g;
    req_valid  = v.mask;
    req_r_wb   = v.rwb;
    req_addr   = v.addr;
    req_data_w = v.dw;
    tick();
    chk("issue_valid", C_in_valid, 1);
    chk("req_ready", req_ready, 2'b01 << g);
    chk("c_r_wb", C_r_wb, v.rwb[g]);
    chk("c_addr", C_addr, v.addr[g*8 +: 8]);
    chk("c_data_w", C_data_w, v.dw[g*32 +: 32]);
    chk("busy_issue", busy, 1);
    req_valid[g] = 1'b0;
    n = 0;
    while (n < 40) begin
      C_out_valid = (n == v.lat);
      C_data_r    = (n == v.lat) ? v.rdata : 32'h0BAD0BAD;
      tick();
      n++;
      if (n == 1) chk("c_addr_hold", C_addr, v.addr[g*8 +: 8]);
      if (resp_valid != 2'b00) break;
    end
    C_out_valid = 1'b0;
    exp_n    = (v.lat >= 1 && v.lat <= 8) ? v.lat + 1 : 9;
    exp_data = v.exp_err ? 32'h0 : v.rdata;
    chk("resp_cycles", n, exp_n);
    chk("resp_valid", resp_valid, 2'b01 << g);
    chk("resp_data", resp_data, exp_data);
    chk("resp_err", resp_err, v.exp_err);
    chk("timeout_err", timeout_err, v.exp_terr);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_c_addr", C_addr, 0);
    chk("resp_data_hold", resp_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = '{2'b01, 2'b01, 16'h002A, 64'h0,                  5,  32'hDEADBEEF, 0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 16'h0700, 64'h11223344_00000000,  3,  32'hA5A5A5A5, 1, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 2'b10, 16'h3130, 64'hB1000001_A0000001,  1,  32'h00000100, 0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 2'b10, 16'h3130, 64'hB1000001_A0000001,  2,  32'h00000101, 1, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 2'b10, 16'h3130, 64'hB1000001_A0000001,  4,  32'h00000102, 0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 2'b10, 16'h3130, 64'hB1000001_A0000001,  7,  32'h00000103, 1, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 2'b01, 16'h0055, 64'h0,                  8,  32'h12345678, 0, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 2'b10, 16'h6600, 64'h0,                  99, 32'hCAFEF00D, 1, 1'b1, 1'b1};
    vecs[8] = '{2'b01, 2'b00, 16'h0011, 64'h0BADF00D,           2,  32'hFEEDFACE, 0, 1'b0, 1'b1};
    vecs[9] = '{2'b11, 2'b11, 16'h4443, 64'h0,                  2,  32'h5A5A0001, 0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    req_valid   = '0;
    req_r_wb    = '0;
    req_addr    = '0;
    req_data_w  = '0;
    C_out_valid = 1'b0;
    C_data_r    = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_c_in_valid", C_in_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_c_fields", {C_r_wb, C_addr, C_data_w}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Stray completion while idle must change nothing.
    C_out_valid = 1'b1;
    C_data_r    = 32'h77777777;
    tick();
    C_out_valid = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_resp_valid", resp_valid, 0);
    tick();
    chk("stray_resp_data", resp_data, 32'hFEEDFACE);
    chk("stray_busy2", busy, 0);

    // Reset while waiting, then a late bridge completion.
    req_valid = 2'b01;
    req_addr  = 16'h0077;
    tick();
    chk("rw_req_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    tick();
    chk("rw_busy_wait", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("rw_busy_rst", busy, 0);
    chk("rw_timeout_err_clr", timeout_err, 0);
    rst_n       = 1'b1;
    C_out_valid = 1'b1;
    C_data_r    = 32'h99999999;
    tick();
    C_out_valid = 1'b0;
    chk("rw_late_resp_valid", resp_valid, 0);
    chk("rw_late_busy", busy, 0);
    tick();
    chk("rw_late_resp_valid2", resp_valid, 0);
    chk("rw_resp_data", resp_data, 0);
    run_txn(vecs[9]);
    req_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
